// File: rtl/module_hazard_fwd_ctrl.sv
// rtl/module_hazard_fwd_ctrl.sv - RV32I 5-stage hazard/forwarding controller
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module module_hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] rs1_d_i,
    input  logic [REG_ADDR_W-1:0] rs2_d_i,
    input  logic [REG_ADDR_W-1:0] rd_d_i,
    input  logic                  regwrite_d_i,
    input  logic                  load_d_i,
    input  logic                  memop_d_i,
    input  logic                  pcsrc_e_i,
    input  logic                  mem_ready_i,
    output logic [1:0]            forward_a_e_o,
    output logic [1:0]            forward_b_e_o,
    output logic                  stall_f_o,
    output logic                  stall_d_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic                  freeze_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      freeze_cnt_o
`endif
);

    logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic                  rw_e, ld_e, mem_e, rw_m, mem_m, rw_w;
    logic                  freeze, branch, load_use, lu_stall;

    // M result beats W result; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  wm,
        input logic [REG_ADDR_W-1:0] dm,
        input logic                  ww,
        input logic [REG_ADDR_W-1:0] dw
    );
        if (wm && (dm != '0) && (dm == rs))
            return 2'b10;
        else if (ww && (dw != '0) && (dw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        freeze   = rst_n_i & mem_m & ~mem_ready_i;
        load_use = ld_e & (rd_e != '0) & ((rd_e == rs1_d_i) | (rd_e == rs2_d_i));
        branch   = rst_n_i & pcsrc_e_i & ~freeze;
        lu_stall = rst_n_i & load_use & ~pcsrc_e_i & ~freeze;
    end

    assign freeze_o  = freeze;
    assign stall_f_o = lu_stall;
    assign stall_d_o = lu_stall;
    assign flush_d_o = branch;
    assign flush_e_o = branch | lu_stall;

    assign forward_a_e_o = rst_n_i ? fwd_sel(rs1_e, rw_m, rd_m, rw_w, rd_w) : 2'b00;
    assign forward_b_e_o = rst_n_i ? fwd_sel(rs2_e, rw_m, rd_m, rw_w, rd_w) : 2'b00;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rs1_e <= '0;
            rs2_e <= '0;
            rd_e  <= '0;
            rw_e  <= 1'b0;
            ld_e  <= 1'b0;
            mem_e <= 1'b0;
            rd_m  <= '0;
            rw_m  <= 1'b0;
            mem_m <= 1'b0;
            rd_w  <= '0;
            rw_w  <= 1'b0;
        end else if (!freeze) begin
            // A flushed or stalled E slot becomes an all-zero bubble.
            if (branch || lu_stall) begin
                rs1_e <= '0;
                rs2_e <= '0;
                rd_e  <= '0;
                rw_e  <= 1'b0;
                ld_e  <= 1'b0;
                mem_e <= 1'b0;
            end else begin
                rs1_e <= rs1_d_i;
                rs2_e <= rs2_d_i;
                rd_e  <= rd_d_i;
                rw_e  <= regwrite_d_i;
                ld_e  <= load_d_i;
                mem_e <= memop_d_i;
            end
            rd_m  <= rd_e;
            rw_m  <= rw_e;
            mem_m <= mem_e;
            rd_w  <= rd_m;
            rw_w  <= rw_m;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_o  <= '0;
            flush_cnt_o  <= '0;
            freeze_cnt_o <= '0;
        end else begin
            if (lu_stall)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (branch)
                flush_cnt_o <= flush_cnt_o + 1'b1;
            if (freeze)
                freeze_cnt_o <= freeze_cnt_o + 1'b1;
        end
    end
`endif

endmodule
